l2_host_tag_ctrl: RTL and testbench

//  Host-side tag manager directly downstream of the L2 stream controller's host request port.

---
 rtl/l2_host_tag_ctrl.sv | 178 +++++++++++++++++
 tb/tb_l2_host_tag_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_host_tag_ctrl.sv
// Host tag manager: allocates a host tag per cache-line fetch, issues tagged host requests,
// and turns out-of-order multi-beat host responses into URAM writes plus per-line completions.
module l2_host_tag_ctrl #(
   parameter int addr_width   = 64,
   parameter int cache_line   = 128,
   parameter int nstrms       = 64,
   parameter int nstrms_width = $clog2(nstrms),
   parameter int ntags        = 32,
   parameter int tag_width    = $clog2(ntags),
   parameter int beat_width   = 512,
   parameter int nbeats       = cache_line * 8 / beat_width,
   parameter int beat_cw      = (nbeats > 1) ? $clog2(nbeats) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_req_v,
   output logic                    i_req_r,
   input  logic [nstrms_width-1:0] i_req_sid,
   input  logic [addr_width-1:0]   i_req_ea,
   output logic                    o_hreq_v,
   input  logic                    o_hreq_r,
   output logic [tag_width-1:0]    o_hreq_tag,
   output logic [addr_width-1:0]   o_hreq_ea,
   input  logic                    i_hrsp_v,
   output logic                    i_hrsp_r,
   input  logic [tag_width-1:0]    i_hrsp_tag,
   input  logic                    i_hrsp_last,
   input  logic [beat_width-1:0]   i_hrsp_data,
   output logic                    o_wr_v,
   output logic [nstrms_width-1:0] o_wr_sid,
   output logic [beat_cw-1:0]      o_wr_beat,
   output logic [beat_width-1:0]   o_wr_data,
   output logic                    o_rsp_v,
   input  logic                    i_rsp_r,
   output logic [nstrms_width-1:0] o_rsp_sid,
   output logic [tag_width:0]      o_outst,
   output logic                    o_err
);

   logic [ntags-1:0]        busy_q, busy_d;
   logic [nstrms_width-1:0] tag_sid_q [ntags];
   logic                    hreq_v_q, hreq_v_d;
   logic [tag_width-1:0]    hreq_tag_q, hreq_tag_d;
   logic [addr_width-1:0]   hreq_ea_q, hreq_ea_d;
   logic [beat_cw-1:0]      cnt_q, cnt_d;
   logic                    wr_v_q, wr_v_d;
   logic [nstrms_width-1:0] wr_sid_q, wr_sid_d;
   logic [beat_cw-1:0]      wr_beat_q, wr_beat_d;
   logic [beat_width-1:0]   wr_data_q, wr_data_d;
   logic                    rsp_v_q, rsp_v_d;
   logic [nstrms_width-1:0] rsp_sid_q, rsp_sid_d;
   logic [tag_width:0]      outst_q, outst_d;
   logic                    err_q, err_d;

   logic                    any_free;
   logic [tag_width-1:0]    free_idx;
   logic                    req_acc, hrsp_acc, tag_hit, beat_ok, last_done, cnt_last;
   logic [nstrms_width-1:0] hit_sid;

   // Lowest-index free tag, searched over the registered busy vector only
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = ntags - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_idx = tag_width'(i);
            any_free = 1'b1;
         end
      end
   end

   assign i_req_r   = any_free & (~hreq_v_q | o_hreq_r);
   assign req_acc   = i_req_v & i_req_r;
   assign i_hrsp_r  = ~(rsp_v_q & ~i_rsp_r);
   assign hrsp_acc  = i_hrsp_v & i_hrsp_r;
   assign tag_hit   = busy_q[i_hrsp_tag];
   assign beat_ok   = hrsp_acc & tag_hit;
   assign last_done = beat_ok & i_hrsp_last;
   assign cnt_last  = (cnt_q == beat_cw'(nbeats - 1));
   assign hit_sid   = tag_sid_q[i_hrsp_tag];

   always_comb begin
      busy_d     = busy_q;
      hreq_v_d   = hreq_v_q;
      hreq_tag_d = hreq_tag_q;
      hreq_ea_d  = hreq_ea_q;
      cnt_d      = cnt_q;
      wr_v_d     = beat_ok;
      wr_sid_d   = wr_sid_q;
      wr_beat_d  = wr_beat_q;
      wr_data_d  = wr_data_q;
      rsp_v_d    = rsp_v_q;
      rsp_sid_d  = rsp_sid_q;
      outst_d    = outst_q;
      err_d      = err_q | (hrsp_acc & ~tag_hit) | (beat_ok & (i_hrsp_last != cnt_last));

      if (last_done) busy_d[i_hrsp_tag] = 1'b0;
      if (req_acc)   busy_d[free_idx]   = 1'b1;

      if (req_acc) begin
         hreq_v_d   = 1'b1;
         hreq_tag_d = free_idx;
         hreq_ea_d  = i_req_ea;
      end else if (o_hreq_r) begin
         hreq_v_d = 1'b0;
      end

      // Malformed beat sequences are still written and completed; only o_err records them
      if (beat_ok) begin
         wr_sid_d  = hit_sid;
         wr_beat_d = cnt_q;
         wr_data_d = i_hrsp_data;
         cnt_d     = i_hrsp_last ? '0 : cnt_q + beat_cw'(1);
      end

      if (last_done) begin
         rsp_v_d   = 1'b1;
         rsp_sid_d = hit_sid;
      end else if (i_rsp_r) begin
         rsp_v_d = 1'b0;
      end

      case ({req_acc, last_done})
         2'b10:   outst_d = outst_q + (tag_width + 1)'(1);
         2'b01:   outst_d = outst_q - (tag_width + 1)'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (req_acc) tag_sid_q[free_idx] <= i_req_sid;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q     <= '0;
         hreq_v_q   <= 1'b0;
         hreq_tag_q <= '0;
         hreq_ea_q  <= '0;
         cnt_q      <= '0;
         wr_v_q     <= 1'b0;
         wr_sid_q   <= '0;
         wr_beat_q  <= '0;
         wr_data_q  <= '0;
         rsp_v_q    <= 1'b0;
         rsp_sid_q  <= '0;
         outst_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         hreq_v_q   <= hreq_v_d;
         hreq_tag_q <= hreq_tag_d;
         hreq_ea_q  <= hreq_ea_d;
         cnt_q      <= cnt_d;
         wr_v_q     <= wr_v_d;
         wr_sid_q   <= wr_sid_d;
         wr_beat_q  <= wr_beat_d;
         wr_data_q  <= wr_data_d;
         rsp_v_q    <= rsp_v_d;
         rsp_sid_q  <= rsp_sid_d;
         outst_q    <= outst_d;
         err_q      <= err_d;
      end
   end

   assign o_hreq_v   = hreq_v_q;
   assign o_hreq_tag = hreq_tag_q;
   assign o_hreq_ea  = hreq_ea_q;
   assign o_wr_v     = wr_v_q;
   assign o_wr_sid   = wr_sid_q;
   assign o_wr_beat  = wr_beat_q;
   assign o_wr_data  = wr_data_q;
   assign o_rsp_v    = rsp_v_q;
   assign o_rsp_sid  = rsp_sid_q;
   assign o_outst    = outst_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_l2_host_tag_ctrl.sv
// Scoreboard bench for l2_host_tag_ctrl: stimulus pushes expected host requests, URAM writes
// and completions into queues; a negedge monitor pops and compares them as the DUT emits them.
module tb_l2_host_tag_ctrl;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         i_req_v, i_req_r;
   logic [5:0]   i_req_sid;
   logic [63:0]  i_req_ea;
   logic         o_hreq_v, o_hreq_r;
   logic [4:0]   o_hreq_tag;
   logic [63:0]  o_hreq_ea;
   logic         i_hrsp_v, i_hrsp_r;
   logic [4:0]   i_hrsp_tag;
   logic         i_hrsp_last;
   logic [511:0] i_hrsp_data;
   logic         o_wr_v;
   logic [5:0]   o_wr_sid;
   logic [0:0]   o_wr_beat;
   logic [511:0] o_wr_data;
   logic         o_rsp_v, i_rsp_r;
   logic [5:0]   o_rsp_sid;
   logic [5:0]   o_outst;
   logic         o_err;

   always #5 clk = ~clk;

   l2_host_tag_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
      .o_hreq_v(o_hreq_v), .o_hreq_r(o_hreq_r), .o_hreq_tag(o_hreq_tag), .o_hreq_ea(o_hreq_ea),
      .i_hrsp_v(i_hrsp_v), .i_hrsp_r(i_hrsp_r), .i_hrsp_tag(i_hrsp_tag),
      .i_hrsp_last(i_hrsp_last), .i_hrsp_data(i_hrsp_data),
      .o_wr_v(o_wr_v), .o_wr_sid(o_wr_sid), .o_wr_beat(o_wr_beat), .o_wr_data(o_wr_data),
      .o_rsp_v(o_rsp_v), .i_rsp_r(i_rsp_r), .o_rsp_sid(o_rsp_sid),
      .o_outst(o_outst), .o_err(o_err)
   );

   typedef struct packed {
      logic [5:0]   sid;
      logic [0:0]   beat;
      logic [511:0] data;
   } wr_t;

   int         checks = 0;
   int         errors = 0;
   logic [68:0] hreq_q [$];
   wr_t         wr_q [$];
   logic [5:0]  rsp_q [$];
   logic [5:0]  sid_of [32];

   function automatic logic [511:0] mkdata(input int n);
      logic [31:0] w;
      w = 32'hC0DE0000 + n[31:0];
      return {16{w}} ^ {{480{1'b0}}, n[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples on the falling edge, between input updates and the next active edge
   initial begin
      logic [68:0] eh;
      wr_t         ew;
      logic [5:0]  er;
      forever begin
         @(negedge clk);
         if (o_hreq_v && o_hreq_r) begin
            if (hreq_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL hreq_unexpected got tag %0d ea %0h expected none", o_hreq_tag, o_hreq_ea);
            end else begin
               eh = hreq_q.pop_front();
               chk("hreq_tag", 64'(o_hreq_tag), 64'(eh[68:64]));
               chk("hreq_ea", o_hreq_ea, eh[63:0]);
            end
         end
         if (o_wr_v) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected got sid %0d beat %0d expected none", o_wr_sid, o_wr_beat);
            end else begin
               ew = wr_q.pop_front();
               chk("wr_sid", 64'(o_wr_sid), 64'(ew.sid));
               chk("wr_beat", 64'(o_wr_beat), 64'(ew.beat));
               checks++;
               if (o_wr_data !== ew.data) begin
                  errors++;
                  $display("FAIL wr_data got %0h expected %0h", o_wr_data[63:0], ew.data[63:0]);
               end
            end
         end
         if (o_rsp_v && i_rsp_r) begin
            if (rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp_unexpected got sid %0d expected none", o_rsp_sid);
            end else begin
               er = rsp_q.pop_front();
               chk("rsp_sid", 64'(o_rsp_sid), 64'(er));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_req(input logic [5:0] sid, input logic [63:0] ea, input logic [4:0] tag);
      int n = 0;
      i_req_v = 1'b1; i_req_sid = sid; i_req_ea = ea;
      while (!i_req_r && n < 50) begin step(); n++; end
      if (!i_req_r) begin
         checks++; errors++;
         $display("FAIL req_ready_timeout got 0 expected 1");
      end
      step();
      hreq_q.push_back({tag, ea});
      sid_of[tag] = sid;
      i_req_v = 1'b0;
   endtask

   task automatic send_beat(input logic [4:0] tag, input logic last, input int n,
                            input logic do_wr, input logic [0:0] beat, input logic do_rsp);
      int k = 0;
      wr_t w;
      i_hrsp_v = 1'b1; i_hrsp_tag = tag; i_hrsp_last = last; i_hrsp_data = mkdata(n);
      while (!i_hrsp_r && k < 50) begin step(); k++; end
      if (!i_hrsp_r) begin
         checks++; errors++;
         $display("FAIL hrsp_ready_timeout got 0 expected 1");
      end
      step();
      if (do_wr) begin
         w.sid = sid_of[tag]; w.beat = beat; w.data = mkdata(n);
         wr_q.push_back(w);
      end
      if (do_rsp) rsp_q.push_back(sid_of[tag]);
      i_hrsp_v = 1'b0; i_hrsp_last = 1'b0;
   endtask

   task automatic complete(input logic [4:0] tag, input int n);
      send_beat(tag, 1'b0, n, 1'b1, 1'b0, 1'b0);
      send_beat(tag, 1'b1, n + 1, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string tagname);
      chk({tagname, "_hreq_v"}, 64'(o_hreq_v), 64'd0);
      chk({tagname, "_hreq_tag"}, 64'(o_hreq_tag), 64'd0);
      chk({tagname, "_hreq_ea"}, o_hreq_ea, 64'd0);
      chk({tagname, "_wr_v"}, 64'(o_wr_v), 64'd0);
      chk({tagname, "_wr_sid"}, 64'(o_wr_sid), 64'd0);
      chk({tagname, "_rsp_v"}, 64'(o_rsp_v), 64'd0);
      chk({tagname, "_rsp_sid"}, 64'(o_rsp_sid), 64'd0);
      chk({tagname, "_outst"}, 64'(o_outst), 64'd0);
      chk({tagname, "_err"}, 64'(o_err), 64'd0);
   endtask

   task automatic pulse_reset(input string tagname);
      reset_n = 1'b0;
      #2;
      chk_reset_outputs({tagname, "_during"});
      step(); step();
      reset_n = 1'b1;
      step();
      chk_reset_outputs({tagname, "_after"});
   endtask

   initial begin
      reset_n = 1'b0;
      i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0;
      o_hreq_r = 1'b1;
      i_hrsp_v = 1'b0; i_hrsp_tag = '0; i_hrsp_last = 1'b0; i_hrsp_data = '0;
      i_rsp_r = 1'b1;
      for (int i = 0; i < 32; i++) sid_of[i] = '0;
      step(); step(); step();
      reset_n = 1'b1;
      step();
      chk_reset_outputs("reset");
      chk("reset_req_r", 64'(i_req_r), 64'd1);
      chk("reset_hrsp_r", 64'(i_hrsp_r), 64'd1);

      // Single line
      send_req(6'd5, 64'h1000, 5'd0);
      chk("t1_outst_1", 64'(o_outst), 64'd1);
      complete(5'd0, 10);
      chk("t1_outst_0", 64'(o_outst), 64'd0);
      chk("t1_err", 64'(o_err), 64'd0);

      // Full: 32 back-to-back requests, then recycle tag 7
      for (int t = 0; t < 32; t++) send_req(6'(t), 64'(t) * 64'h80, 5'(t));
      chk("t2_req_r_full", 64'(i_req_r), 64'd0);
      chk("t2_outst_32", 64'(o_outst), 64'd32);
      complete(5'd7, 20);
      chk("t2_outst_31", 64'(o_outst), 64'd31);
      send_req(6'd40, 64'h9000, 5'd7);
      chk("t2_outst_32b", 64'(o_outst), 64'd32);
      for (int t = 0; t < 32; t++) complete(5'(t), 100 + 2 * t);
      chk("t2_outst_drained", 64'(o_outst), 64'd0);

      // Out-of-order completion
      send_req(6'd1, 64'h100, 5'd0);
      send_req(6'd2, 64'h200, 5'd1);
      send_req(6'd3, 64'h300, 5'd2);
      complete(5'd2, 200);
      complete(5'd0, 210);
      complete(5'd1, 220);
      chk("t3_outst", 64'(o_outst), 64'd0);

      // Completion backpressure stalls host beats
      send_req(6'd9, 64'h400, 5'd0);
      send_req(6'd10, 64'h500, 5'd1);
      i_rsp_r = 1'b0;
      complete(5'd0, 300);
      i_hrsp_v = 1'b1; i_hrsp_tag = 5'd1; i_hrsp_last = 1'b0; i_hrsp_data = mkdata(310);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t4_hrsp_r_stall", 64'(i_hrsp_r), 64'd0);
         chk("t4_wr_v_stall", 64'(o_wr_v), 64'd0);
         chk("t4_rsp_v_hold", 64'(o_rsp_v), 64'd1);
      end
      i_rsp_r = 1'b1;
      #1;
      chk("t4_hrsp_r_release", 64'(i_hrsp_r), 64'd1);
      step();
      begin
         wr_t w;
         w.sid = 6'd10; w.beat = 1'b0; w.data = mkdata(310);
         wr_q.push_back(w);
      end
      i_hrsp_v = 1'b0;
      send_beat(5'd1, 1'b1, 311, 1'b1, 1'b1, 1'b1);

      // Host request backpressure holds tag/ea
      o_hreq_r = 1'b0;
      send_req(6'd11, 64'h2000, 5'd0);
      for (int c = 0; c < 3; c++) begin
         chk("t4_hreq_v_hold", 64'(o_hreq_v), 64'd1);
         chk("t4_hreq_tag_hold", 64'(o_hreq_tag), 64'd0);
         chk("t4_hreq_ea_hold", o_hreq_ea, 64'h2000);
         chk("t4_req_r_blocked", 64'(i_req_r), 64'd0);
         step();
      end
      o_hreq_r = 1'b1;
      step();
      complete(5'd0, 320);
      chk("t4_outst", 64'(o_outst), 64'd0);
      chk("t4_err", 64'(o_err), 64'd0);

      // Errors: beat on a free tag, then a short line
      send_beat(5'd9, 1'b1, 400, 1'b0, 1'b0, 1'b0);
      chk("t5_free_err", 64'(o_err), 64'd1);
      chk("t5_free_wr_v", 64'(o_wr_v), 64'd0);
      chk("t5_free_rsp_v", 64'(o_rsp_v), 64'd0);
      chk("t5_free_outst", 64'(o_outst), 64'd0);
      step();
      pulse_reset("t5_rst");
      send_req(6'd12, 64'h3000, 5'd0);
      send_beat(5'd0, 1'b1, 410, 1'b1, 1'b0, 1'b1);
      chk("t5_short_err", 64'(o_err), 64'd1);
      chk("t5_short_rsp_v", 64'(o_rsp_v), 64'd1);
      chk("t5_short_outst", 64'(o_outst), 64'd0);
      step();

      // Reset mid-flight, then a stale-tag response
      pulse_reset("t6_pre");
      for (int t = 0; t < 4; t++) send_req(6'(20 + t), 64'h4000 + 64'(t) * 64'h80, 5'(t));
      chk("t6_outst_4", 64'(o_outst), 64'd4);
      step();
      pulse_reset("t6_rst");
      send_beat(5'd2, 1'b0, 500, 1'b0, 1'b0, 1'b0);
      chk("t6_stale_err", 64'(o_err), 64'd1);
      chk("t6_stale_wr_v", 64'(o_wr_v), 64'd0);
      chk("t6_stale_outst", 64'(o_outst), 64'd0);

      step(); step(); step();
      chk("end_hreq_q_empty", 64'(hreq_q.size()), 64'd0);
      chk("end_wr_q_empty", 64'(wr_q.size()), 64'd0);
      chk("end_rsp_q_empty", 64'(rsp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
